// File: rtl/period_reciprocal_if.sv
// Bus bundle between a period source and period_reciprocal: DURATION/EDGE_FLAG in, FREQ results out.
interface period_reciprocal_if #(
  parameter int IN_BITS  = 32,
  parameter int OUT_BITS = 32
);
  logic                EDGE_FLAG;
  logic [IN_BITS-1:0]  DURATION;
  logic [OUT_BITS-1:0] FREQ;
  logic                FREQ_VALID;
  logic                BUSY;
  logic [7:0]          DROP_CNT;

  modport master (
    output EDGE_FLAG, DURATION,
    input  FREQ, FREQ_VALID, BUSY, DROP_CNT
  );

  modport slave (
    input  EDGE_FLAG, DURATION,
    output FREQ, FREQ_VALID, BUSY, DROP_CNT
  );
endinterface

// File: rtl/period_reciprocal.sv
// FREQ = 2^NUM_SHIFT / DURATION via a one-bit-per-clock restoring divider with a 1-deep pending slot.
// Define PERIOD_RECIP_ROUND_EN for round-to-nearest; otherwise the quotient is truncated.
module period_reciprocal #(
  parameter int IN_BITS   = 32,
  parameter int OUT_BITS  = 32,
  parameter int NUM_SHIFT = 40
) (
  input  logic               CLK,
  input  logic               RESET_N,
  period_reciprocal_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;

  localparam int CNT_W   = $clog2(OUT_BITS + 1);
  localparam int SAT_EXP = NUM_SHIFT - OUT_BITS;
  // Numerator bits above the quotient window; D at or below this overflows OUT_BITS.
  localparam logic [IN_BITS:0] REM_INIT = {{IN_BITS{1'b0}}, 1'b1} << SAT_EXP;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OUT_BITS-1:0] freq_q, freq_d;
  logic                freq_valid_q, freq_valid_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic                pend_full_q, pend_full_d;

  logic [IN_BITS-1:0]  div_q, div_d;
  logic [IN_BITS:0]    rem_q, rem_d;
  logic [OUT_BITS-1:0] quo_q, quo_d;
  logic [IN_BITS-1:0]  pend_q, pend_d;
  logic                sat_q, sat_d;

  logic [IN_BITS+1:0]  shifted;
  logic [IN_BITS+1:0]  trial;
  logic                q_bit;
  logic                busy;
  logic [OUT_BITS-1:0] rounded;

`ifdef PERIOD_RECIP_ROUND_EN
  function automatic logic [OUT_BITS-1:0] round_nearest(
    input logic [OUT_BITS-1:0] q,
    input logic [IN_BITS:0]    rem,
    input logic [IN_BITS-1:0]  d
  );
    if (({rem, 1'b0} >= {2'b00, d}) && (q != {OUT_BITS{1'b1}}))
      return q + {{(OUT_BITS-1){1'b0}}, 1'b1};
    return q;
  endfunction

  assign rounded = round_nearest(quo_q, rem_q, div_q);
`else
  assign rounded = quo_q;
`endif

  assign busy = (state_q != S_IDLE);

  // Numerator 2^NUM_SHIFT has no set bits below the initial window, so a zero is shifted in.
  assign shifted = {rem_q, 1'b0};
  assign trial   = shifted - {2'b00, div_q};
  assign q_bit   = ~trial[IN_BITS+1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    freq_d       = freq_q;
    freq_valid_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    pend_full_d  = pend_full_q;
    div_d        = div_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    pend_d       = pend_q;
    sat_d        = sat_q;

    if (busy && bus.EDGE_FLAG) begin
      pend_d      = bus.DURATION;
      pend_full_d = 1'b1;
      if (pend_full_q && (state_q != S_DONE))
        drop_cnt_d = (drop_cnt_q == 8'hFF) ? 8'hFF : drop_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.EDGE_FLAG) begin
          div_d   = bus.DURATION;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sat_d   = ({1'b0, div_q} <= REM_INIT);
        rem_d   = REM_INIT;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_d = q_bit ? trial[IN_BITS:0] : shifted[IN_BITS:0];
        quo_d = {quo_q[OUT_BITS-2:0], q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OUT_BITS - 1))
          state_d = S_DONE;
      end
      S_DONE: begin
        freq_d       = sat_q ? {OUT_BITS{1'b1}} : rounded;
        freq_valid_d = 1'b1;
        if (pend_full_q) begin
          // Slot consumed; a coincident strobe refills it rather than counting as a drop.
          div_d       = pend_q;
          pend_full_d = bus.EDGE_FLAG;
          state_d     = S_LOAD;
        end else if (bus.EDGE_FLAG) begin
          div_d       = bus.DURATION;
          pend_full_d = 1'b0;
          state_d     = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
      drop_cnt_q   <= '0;
      pend_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
      drop_cnt_q   <= drop_cnt_d;
      pend_full_q  <= pend_full_d;
    end
  end

  always_ff @(posedge CLK) begin
    div_q  <= div_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    pend_q <= pend_d;
    sat_q  <= sat_d;
  end

  assign bus.FREQ       = freq_q;
  assign bus.FREQ_VALID = freq_valid_q;
  assign bus.BUSY       = busy;
  assign bus.DROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_period_reciprocal.sv
// Scoreboard bench for period_reciprocal: expected FREQ words queued at each strobe, checked on FREQ_VALID.
module tb_period_reciprocal;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] sb[$];
  logic        prev_fv;

  period_reciprocal_if #(.IN_BITS(32), .OUT_BITS(32)) bus ();

  period_reciprocal #(.IN_BITS(32), .OUT_BITS(32), .NUM_SHIFT(40)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_freq(input logic [31:0] d);
    logic [63:0] num;
    logic [63:0] q;
    logic [63:0] r;
    if (d <= 32'd256) return 32'hFFFF_FFFF;
    num = 64'd1 << 40;
    q   = num / {32'd0, d};
    r   = num % {32'd0, d};
`ifdef PERIOD_RECIP_ROUND_EN
    if (((r << 1) >= {32'd0, d}) && (q[31:0] != 32'hFFFF_FFFF)) q = q + 64'd1;
`else
    r = r;
`endif
    return q[31:0];
  endfunction

  // Result monitor: every FREQ_VALID pops one expected value.
  always @(negedge clk) begin
    if (bus.FREQ_VALID === 1'b1) begin
      total = total + 1;
      if (sb.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_result got=%h expected=none", bus.FREQ);
      end else begin
        logic [31:0] exp_v;
        exp_v = sb.pop_front();
        if (bus.FREQ !== exp_v) begin
          bad = bad + 1;
          $display("FAIL freq_value got=%h expected=%h", bus.FREQ, exp_v);
        end
      end
      total = total + 1;
      if (prev_fv !== 1'b0) begin
        bad = bad + 1;
        $display("FAIL valid_back_to_back got=%b expected=0", prev_fv);
      end
    end
    prev_fv = bus.FREQ_VALID;
  end

  task automatic pulse(input logic [31:0] d);
    bus.EDGE_FLAG = 1'b1;
    bus.DURATION  = d;
    @(posedge clk); #1;
    bus.EDGE_FLAG = 1'b0;
    bus.DURATION  = $urandom;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if ((sb.size() == 0) && (bus.BUSY === 1'b0)) begin
        done = 1'b1;
        break;
      end
    end
    total = total + 1;
    if (!done) begin
      bad = bad + 1;
      $display("FAIL drain_timeout got=pending%0d expected=pending0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.EDGE_FLAG = 1'b0;
    bus.DURATION  = 32'h0001_0000;
    repeat (3) @(posedge clk);
    #1;
    total = total + 4;
    if (bus.FREQ !== 32'd0) begin bad++; $display("FAIL reset_freq got=%h expected=0", bus.FREQ); end
    if (bus.FREQ_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b expected=0", bus.FREQ_VALID); end
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b expected=0", bus.BUSY); end
    if (bus.DROP_CNT !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d expected=0", bus.DROP_CNT); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.DURATION = $urandom;
    end
    total = total + 1;
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL no_strobe_busy got=%b expected=0", bus.BUSY); end
  endtask

  task automatic test_latency(input logic [31:0] d, input logic [31:0] exp_v);
    bit early;
    @(posedge clk); #1;
    sb.push_back(exp_v);
    pulse(d);
    total = total + 1;
    if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL busy_after_capture got=%b expected=1", bus.BUSY); end
    early = 1'b0;
    repeat (33) begin
      @(posedge clk); #1;
      if (bus.FREQ_VALID !== 1'b0) early = 1'b1;
    end
    total = total + 1;
    if (early) begin bad++; $display("FAIL latency_early got=early expected=edge34"); end
    @(posedge clk); #1;
    total = total + 2;
    if (bus.FREQ_VALID !== 1'b1) begin bad++; $display("FAIL latency_valid got=%b expected=1", bus.FREQ_VALID); end
    if (bus.FREQ !== exp_v) begin bad++; $display("FAIL latency_freq got=%h expected=%h", bus.FREQ, exp_v); end
    @(posedge clk); #1;
    total = total + 2;
    if (bus.FREQ_VALID !== 1'b0) begin bad++; $display("FAIL valid_width got=%b expected=0", bus.FREQ_VALID); end
    if (bus.FREQ !== exp_v) begin bad++; $display("FAIL freq_hold got=%h expected=%h", bus.FREQ, exp_v); end
    wait_drain();
  endtask

  task automatic test_values();
    logic [31:0] dv [6];
    logic [31:0] ev [6];
    dv = '{32'd257, 32'd256, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd12345};
`ifdef PERIOD_RECIP_ROUND_EN
    ev[0] = 32'hFF00_FF01;
`else
    ev[0] = 32'hFF00_FF00;
`endif
    ev[1] = 32'hFFFF_FFFF;
    ev[2] = 32'hFFFF_FFFF;
    ev[3] = 32'hFFFF_FFFF;
    ev[4] = 32'h0000_0100;
    ev[5] = ref_freq(32'd12345);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      sb.push_back(ev[i]);
      pulse(dv[i]);
      wait_drain();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    int  seen;
    bit  gap;
    bit  done;
    a = 32'h0003_0001;
    b = 32'h0000_0777;
    c = 32'h00AB_CDEF;
    @(posedge clk); #1;
    sb.push_back(ref_freq(a));
    pulse(a);
    repeat (4) @(posedge clk);
    #1;
    pulse(b);
    repeat (4) @(posedge clk);
    #1;
    sb.push_back(ref_freq(c));
    pulse(c);
    seen = 0;
    gap  = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (bus.FREQ_VALID === 1'b1) seen++;
      if (seen == 2) begin done = 1'b1; break; end
      if (bus.BUSY !== 1'b1) gap = 1'b1;
      @(posedge clk); #1;
    end
    total = total + 3;
    if (!done) begin bad++; $display("FAIL pending_results got=%0d expected=2", seen); end
    if (gap) begin bad++; $display("FAIL busy_continuous got=gap expected=high"); end
    if (bus.DROP_CNT !== 8'd1) begin bad++; $display("FAIL drop_count got=%0d expected=1", bus.DROP_CNT); end
    wait_drain();
  endtask

  task automatic test_reset_mid_div();
    @(posedge clk); #1;
    sb.push_back(ref_freq(32'h0001_2345));
    pulse(32'h0001_2345);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total = total + 4;
    if (bus.FREQ !== 32'd0) begin bad++; $display("FAIL async_freq got=%h expected=0", bus.FREQ); end
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL async_busy got=%b expected=0", bus.BUSY); end
    if (bus.FREQ_VALID !== 1'b0) begin bad++; $display("FAIL async_valid got=%b expected=0", bus.FREQ_VALID); end
    if (bus.DROP_CNT !== 8'd0) begin bad++; $display("FAIL async_drop got=%0d expected=0", bus.DROP_CNT); end
    #2;
    rst_n = 1'b1;
    sb.delete();
    repeat (45) @(posedge clk);
    #1;
    total = total + 1;
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b expected=0", bus.BUSY); end
    test_latency(32'h0001_0000, 32'h0100_0000);
  endtask

  task automatic test_random_stream();
    logic [31:0] d;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if ((i % 5) == 0) d = $urandom_range(0, 600);
      else              d = $urandom;
      sb.push_back(ref_freq(d));
      pulse(d);
      repeat (38) @(posedge clk);
    end
    wait_drain();
    total = total + 1;
    if (bus.DROP_CNT !== 8'd0) begin bad++; $display("FAIL random_drop got=%0d expected=0", bus.DROP_CNT); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    prev_fv = 1'b0;
    rst_n   = 1'b0;
    bus.EDGE_FLAG = 1'b0;
    bus.DURATION  = '0;
    test_reset();
    test_latency(32'h0001_0000, 32'h0100_0000);
    test_values();
    test_back_to_back();
    test_reset_mid_div();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
